button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Cleans the raw active-low board push-buttons (btn1/btn2 pins, 27 MHz clk) before they reach the
//   LED counter logic. Per channel: 2-FF synchronizer, stable-time debounce filter, active-high
//   debounced level and single-cycle press/release strobes. The counter stage uses these strobes
//   for its counter-clear and enable-toggle controls.
// PARAMETERS
//   N_BTN         2          number of button channels
//   DEBOUNCE_CYC  270000     stable cycles required before a state change (10 ms @ 27 MHz); must be >= 1
//   LONG_CYC      27000000   held-pressed cycles before long strobe (1 s @ 27 MHz); used only with LONG_PRESS_EN
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   btn_n      in   N_BTN  raw button pins, 0 = pressed, asynchronous to clk
//   pressed    out  N_BTN  debounced level, 1 = pressed
//   press_p    out  N_BTN  1-cycle strobe on debounced press
//   release_p  out  N_BTN  1-cycle strobe on debounced release
//   long_p     out  N_BTN  1-cycle strobe after LONG_CYC held cycles (0 when feature compiled out)
// BEHAVIOUR
//   Reset (async assert, sync release): sync FFs = 1 (released), pressed/press_p/release_p/long_p = 0,
//     all counters = 0.
//   Sync: btn_n through 2 FFs; sync_n valid 2 clocks after a pin change. Raw pins never feed logic directly.
//   Filter, per channel, counter width $clog2(DEBOUNCE_CYC+1):
//     - ~sync_n == pressed -> cnt <= 0.
//     - ~sync_n != pressed, cnt < DEBOUNCE_CYC-1 -> cnt <= cnt+1.
//     - ~sync_n != pressed, cnt == DEBOUNCE_CYC-1 -> pressed <= ~sync_n, cnt <= 0, strobe fires.
//   Latency: pin change to pressed change = 2 + DEBOUNCE_CYC clocks when the pin holds stable throughout.
//   Strobes: registered. press_p / release_p are high for exactly the first cycle of the new pressed level.
//     Never both high on one channel in the same cycle.
//   Bounce: any return to the current level before DEBOUNCE_CYC stable cycles clears cnt. No output change.
//   Channels are fully independent; simultaneous events on several channels strobe in the same cycle.
//   Reset mid-debounce: partial count discarded. A button held through reset release reports
//     pressed = 1 and press_p 2+DEBOUNCE_CYC clocks after rst_n rises.
//   All outputs are registered. No combinational path from btn_n to any output.
// CONFIGURATION
//   BUTTON_DEBOUNCE_LONG_PRESS_EN defined:
//     - Per-channel hold counter, width $clog2(LONG_CYC+1). Counts while pressed = 1; cleared while pressed = 0.
//     - When the counter reaches LONG_CYC-1, long_p pulses 1 cycle. Counter then saturates, so exactly one
//       long_p per hold.
//     - Release before the threshold: no long_p. release_p is unaffected by long_p.
//   Not defined: no hold-counter hardware; long_p tied to 0.
// TESTING  (N_BTN=2, DEBOUNCE_CYC=8, LONG_CYC=20)
//   1 Reset: rst_n=0 with btn_n=2'b00 -> all outputs 0. Release reset -> pressed=2'b11 and press_p=2'b11
//     for 1 cycle, 10 clocks later.
//   2 Clean press/release: btn_n[0] 1->0 held -> pressed[0] and 1-cycle press_p[0] 10 clocks after the edge;
//     btn_n[0] 0->1 -> 1-cycle release_p[0] 10 clocks later; channel 1 stays 0 throughout.
//   3 Bounce: btn_n[0] low 5, high 3, low 5, then high -> no change on pressed/press_p/release_p.
//     Then low for 12 -> single press_p[0].
//   4 Simultaneous: both pins fall on the same clk -> press_p=2'b11 in one cycle, once only.
//   5 Mid-debounce reset: pin low 6 cycles, pulse rst_n -> no strobe. After release, full 10-cycle latency
//     before pressed.
//   6 Long press: with LONG_PRESS_EN, hold 40 cycles -> exactly one long_p[0], 20 cycles after press_p[0].
//     Hold 15 then release -> no long_p. Without the define, long_p stays 0.

Source files
------------

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Cleans raw active-low push-button pins before they reach the LED counter
// logic. Each channel has the same path:
//   2-FF synchronizer -> stable-time debounce filter -> registered outputs.
// The outputs are an active-high debounced level and single-cycle press and
// release strobes. An optional long-press detector adds a one-shot strobe once
// a button has been held for LONG_CYC cycles.
//
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN
//   defined   : per-channel hold counter drives long_p
//   undefined : no hold-counter hardware, long_p is tied to 0
//
// Parameters
//   N_BTN         number of button channels
//   DEBOUNCE_CYC  stable cycles required before the level changes (>= 1)
//   LONG_CYC      held-pressed cycles before long_p (long-press build only)
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   btn_n      in   N_BTN  raw button pins, 0 = pressed, asynchronous to clk
//   pressed    out  N_BTN  debounced level, 1 = pressed
//   press_p    out  N_BTN  1-cycle strobe on the first cycle of pressed = 1
//   release_p  out  N_BTN  1-cycle strobe on the first cycle of pressed = 0
//   long_p     out  N_BTN  1-cycle strobe after LONG_CYC held cycles
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned N_BTN        = 2,
    parameter int unsigned DEBOUNCE_CYC = 270000,
    parameter int unsigned LONG_CYC     = 27000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_p,
    output logic [N_BTN-1:0] release_p,
    output logic [N_BTN-1:0] long_p
);

    // Both counters compare against (CYC - 1), so zero would underflow.
    if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_bad_cfg
        $error("button_debounce: DEBOUNCE_CYC and LONG_CYC must be >= 1");
    end

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Synchronizer: reset to 1 so that a button held through reset is seen as
    // a fresh press and has to pass the full debounce time.
    // -------------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce filter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] pressed_q;
    logic [N_BTN-1:0] pressed_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] release_d;
    logic [N_BTN-1:0] level_sync;

    // Active-high view of the synchronized pins.
    assign level_sync = ~sync2_q;

    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (level_sync[i] == pressed_q[i]) begin
                // Agreement (or a bounce back) discards any partial count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // This is the DEBOUNCE_CYC-th consecutive disagreeing cycle.
                cnt_d[i]     = '0;
                pressed_d[i] = level_sync[i];
                press_d[i]   = level_sync[i];
                release_d[i] = ~level_sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed   = pressed_q;
    assign press_p   = press_q;
    assign release_p = release_q;

    // -------------------------------------------------------------------------
    // Long-press detector
    // -------------------------------------------------------------------------
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
    logic [N_BTN-1:0]  long_q;
    logic [N_BTN-1:0]  long_d;

    // The counter parks at LONG_CYC, one past the firing value, so the strobe
    // fires once per hold no matter how long the button stays down.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!pressed_q[i]) begin
                hold_d[i] = '0;
            end else begin
                if (hold_q[i] == HOLD_LAST) begin
                    long_d[i] = 1'b1;
                end
                if (hold_q[i] != HOLD_SAT) begin
                    hold_d[i] = hold_q[i] + HOLD_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                hold_q[i] <= hold_d[i];
            end
            long_q <= long_d;
        end
    end

    assign long_p = long_q;
`else
    assign long_p = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
module tb_button_debounce;

    localparam int unsigned N_BTN = 2;
    localparam int unsigned DEB   = 8;
    localparam int unsigned LONG  = 20;
    localparam int unsigned LAT   = DEB + 2;   // pin edge to level change

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_n = 2'b00;
    logic [1:0] pressed;
    logic [1:0] press_p;
    logic [1:0] release_p;
    logic [1:0] long_p;

    button_debounce #(
        .N_BTN       (N_BTN),
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    (btn_n),
        .pressed  (pressed),
        .press_p  (press_p),
        .release_p(release_p),
        .long_p   (long_p)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  errors = 0;
    bit  done   = 1'b0;

    // Scoreboard entry: at cycle 'at' the outputs must equal these values.
    typedef struct {
        int unsigned at;
        string       name;
        logic [1:0]  lvl;
        logic [1:0]  pr;
        logic [1:0]  rl;
        logic [1:0]  lg;
    } ev_t;

    ev_t        sb[$];
    logic [1:0] exp_lvl   = 2'b00;
    logic [1:0] sched_lvl = 2'b00;

    // Stimulus table record: drive btn_n, hold it, and the strobes it causes.
    typedef struct {
        logic [1:0]  btn;
        int unsigned hold;
        logic [1:0]  pr;
        logic [1:0]  rl;
        string       name;
    } step_t;

    step_t steps[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got pressed=%b press_p=%b release_p=%b long_p=%b want pressed=%b press_p=%b release_p=%b long_p=%b",
                     name, cyc, act[7:6], act[5:4], act[3:2], act[1:0],
                     exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic push(input int unsigned at, input string name, input logic [1:0] lvl,
                        input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lg);
        ev_t e;
        e.at = at; e.name = name; e.lvl = lvl; e.pr = pr; e.rl = rl; e.lg = lg;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input step_t s);
        btn_n = s.btn;
        if (s.pr != 2'b00 || s.rl != 2'b00) begin
            sched_lvl = (sched_lvl | s.pr) & ~s.rl;
            push(cyc + LAT, s.name, sched_lvl, s.pr, s.rl, 2'b00);
        end
        repeat (s.hold) tick();
    endtask

    // Monitor: every cycle either matches a scheduled event or must be quiet.
    always @(negedge clk) begin
        logic [7:0] act;
        ev_t        e;
        act = {pressed, press_p, release_p, long_p};
        if (!done) begin
            if (!rst_n) begin
                exp_lvl = 2'b00;
                check("in_reset", act, 8'h00);
            end else if (sb.size() != 0 && sb[0].at == cyc) begin
                e = sb.pop_front();
                exp_lvl = e.lvl;
                check(e.name, act, {e.lvl, e.pr, e.rl, e.lg});
            end else begin
                check("quiet", act, {exp_lvl, 6'b000000});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        steps[0] = '{2'b10, 14, 2'b01, 2'b00, "clean_press0"};
        steps[1] = '{2'b11, 14, 2'b00, 2'b01, "clean_release0"};
        steps[2] = '{2'b10,  5, 2'b00, 2'b00, "bounce_low1"};
        steps[3] = '{2'b11,  3, 2'b00, 2'b00, "bounce_high1"};
        steps[4] = '{2'b10,  5, 2'b00, 2'b00, "bounce_low2"};
        steps[5] = '{2'b11,  4, 2'b00, 2'b00, "bounce_high2"};
        steps[6] = '{2'b10, 12, 2'b01, 2'b00, "bounce_settle_press"};
        steps[7] = '{2'b11, 14, 2'b00, 2'b01, "bounce_release"};
        steps[8] = '{2'b00, 14, 2'b11, 2'b00, "simul_press"};
        steps[9] = '{2'b11, 14, 2'b00, 2'b11, "simul_release"};

        // Reset with both buttons held down.
        rst_n = 1'b0;
        btn_n = 2'b00;
        repeat (3) tick();
        check("reset_outputs_zero", {pressed, press_p, release_p, long_p}, 8'h00);
        rst_n = 1'b1;
        push(cyc + LAT, "held_through_reset_press", 2'b11, 2'b11, 2'b00, 2'b00);
        repeat (14) tick();
        btn_n = 2'b11;
        push(cyc + LAT, "held_through_reset_release", 2'b00, 2'b00, 2'b11, 2'b00);
        repeat (14) tick();

        // Clean press/release, bounce, simultaneous channels.
        for (int i = 0; i < 10; i++) begin
            apply(steps[i]);
        end

        // Reset in the middle of a debounce count.
        btn_n = 2'b10;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push(cyc + LAT, "post_reset_press", 2'b01, 2'b01, 2'b00, 2'b00);
        repeat (14) tick();
        btn_n = 2'b11;
        push(cyc + LAT, "post_reset_release", 2'b00, 2'b00, 2'b01, 2'b00);
        repeat (14) tick();

        // Long hold: one long_p exactly LONG cycles after press_p.
        btn_n = 2'b10;
        push(cyc + LAT, "long_hold_press", 2'b01, 2'b01, 2'b00, 2'b00);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        push(cyc + LAT + LONG, "long_pulse", 2'b01, 2'b00, 2'b00, 2'b01);
`endif
        repeat (40) tick();
        btn_n = 2'b11;
        push(cyc + LAT, "long_hold_release", 2'b00, 2'b00, 2'b01, 2'b00);
        repeat (14) tick();

        // Short hold: released before the threshold, no long_p.
        btn_n = 2'b10;
        push(cyc + LAT, "short_hold_press", 2'b01, 2'b01, 2'b00, 2'b00);
        repeat (15) tick();
        btn_n = 2'b11;
        push(cyc + LAT, "short_hold_release", 2'b00, 2'b00, 2'b01, 2'b00);
        repeat (30) tick();

        done = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained got %0d pending events want 0 (next: %s)",
                     sb.size(), sb[0].name);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
